// File: rtl/matvec_y_drain.sv
// -----------------------------------------------------------------------------
// matvec_y_drain
//
// Output side of the matrix-vector multiply pipeline. It keeps a valid tag for
// each slot of the multiplier pipeline and drives the pipeline clock enable.
// When a finished vector reaches the end of the pipeline it is copied into a
// one-vector buffer. The buffered vector then leaves one row per beat on a
// valid/ready stream. The pipeline is frozen only when a finished vector is
// waiting and the buffer is still busy with the previous one.
//
// Ports
//   clk      in   clock; all state changes on the rising edge
//   rst      in   synchronous active-high reset
//   s_valid  in   upstream presents a k/x pair to the multiplier this cycle
//   s_ready  out  upstream pair accepted when s_valid && s_ready (equals cen)
//   cen      out  clock enable for the multiply pipeline
//   y        in   packed signed pipeline results, row r at [r*W_Y +: W_Y]
//   m_data   out  signed row result
//   m_row    out  index of the row on m_data
//   m_valid  out  m_data valid
//   m_ready  in   downstream accepts the beat
//   m_last   out  high on the beat that carries row R-1
// -----------------------------------------------------------------------------
module matvec_y_drain #(
    parameter int R   = 2,
    parameter int C   = 2,
    parameter int W_X = 3,
    parameter int W_K = 3,
    parameter int W_Y = W_X + W_K + $clog2(C),
    parameter int LAT = $clog2(C) + 1,
    parameter int W_R = (R > 1) ? $clog2(R) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  cen,
    input  logic [R*W_Y-1:0]      y,
    output logic signed [W_Y-1:0] m_data,
    output logic [W_R-1:0]        m_row,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last
);

    // State
    logic [LAT-1:0]        tag_q, tag_d;       // valid tag for each pipeline slot
    logic signed [W_Y-1:0] buf_q [R];          // capture buffer, one entry per row
    logic                  buf_full_q, buf_full_d;
    logic [W_R-1:0]        row_q, row_d;

    // Handshake terms
    logic tag_top;
    logic row_last;
    logic fire;
    logic drain;
    logic free;
    logic capture;

    always_comb begin
        tag_top  = tag_q[LAT-1];
        row_last = (row_q == W_R'(R - 1));

        m_valid = buf_full_q;
        m_last  = buf_full_q && row_last;
        m_data  = buf_q[row_q];
        m_row   = row_q;

        fire  = m_valid && m_ready;
        drain = fire && m_last;
        // The buffer can take a new vector if it is empty, or if its last
        // row leaves on this same edge.
        free    = !buf_full_q || drain;
        capture = tag_top && free;

        // The pipeline stops only when its oldest slot holds a finished vector
        // that has nowhere to go.
        cen     = !rst && !(tag_top && !free);
        s_ready = cen;
    end

    // Next-state logic
    always_comb begin
        // NOTE: every signal gets a default here, so no path through the block
        // can leave a value unassigned and infer a latch.
        tag_d      = tag_q;
        buf_full_d = buf_full_q;
        row_d      = row_q;

        if (cen) begin
            tag_d[0] = s_valid;
            for (int i = 1; i < LAT; i++) begin
                tag_d[i] = tag_q[i-1];
            end
        end

        // When a drain and a capture happen on the same edge, buf_full stays
        // set and the next vector follows with no bubble.
        if (capture) begin
            buf_full_d = 1'b1;
        end else if (drain) begin
            buf_full_d = 1'b0;
        end

        if (fire) begin
            row_d = row_last ? '0 : row_q + W_R'(1);
        end
    end

    // NOTE: registers use non-blocking assignments. Every flop then samples
    // the values from before the edge, whatever order the blocks run in.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q      <= '0;
            buf_full_q <= 1'b0;
            row_q      <= '0;
        end else begin
            tag_q      <= tag_d;
            buf_full_q <= buf_full_d;
            row_q      <= row_d;
        end
    end

    // NOTE: the data buffer has no reset. buf_full qualifies its contents, so
    // clearing the data would only add reset fan-out.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int r = 0; r < R; r++) begin
                buf_q[r] <= y[r*W_Y +: W_Y];
            end
        end
    end

endmodule

// File: tb/tb_matvec_y_drain.sv
// -----------------------------------------------------------------------------
// tb_matvec_y_drain
//
// Self-checking bench for matvec_y_drain. A behavioural multiplier computes
// y = K*x with plain integer arithmetic and moves each result through LAT
// enabled stages. Bubble slots are filled with random junk. A FIFO scoreboard
// holds the rows of every accepted vector, and each emitted beat must match
// the head of that FIFO.
// -----------------------------------------------------------------------------
module tb_matvec_y_drain;

    localparam int R   = 2;
    localparam int C   = 2;
    localparam int W_X = 3;
    localparam int W_K = 3;
    localparam int W_Y = W_X + W_K + $clog2(C);
    localparam int LAT = $clog2(C) + 1;
    localparam int W_R = (R > 1) ? $clog2(R) : 1;
    localparam int W_V = R * W_Y;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  s_valid;
    logic                  s_ready;
    logic                  cen;
    logic [W_V-1:0]        y;
    logic signed [W_Y-1:0] m_data;
    logic [W_R-1:0]        m_row;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    always #5 clk = ~clk;

    matvec_y_drain #(
        .R(R), .C(C), .W_X(W_X), .W_K(W_K)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .cen    (cen),
        .y      (y),
        .m_data (m_data),
        .m_row  (m_row),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_last (m_last)
    );

    int n_vec = 0;
    int n_err = 0;
    int beats = 0;
    bit mon_en = 1'b0;

    typedef struct {
        int data;
        int row;
    } beat_t;

    beat_t exp_q[$];

    int k_m [R][C];
    int x_v [C];
    int cur_rows [R];

    // ---------------- behavioural multiplier ----------------
    logic [W_V-1:0] pipe [LAT];
    assign y = pipe[LAT-1];

    function automatic void load_vec();
        for (int r = 0; r < R; r++) begin
            int s = 0;
            for (int c = 0; c < C; c++) s += k_m[r][c] * x_v[c];
            cur_rows[r] = s;
        end
    endfunction

    function automatic logic [W_V-1:0] pack_rows();
        logic [W_V-1:0] v;
        for (int r = 0; r < R; r++) v[r*W_Y +: W_Y] = W_Y'(cur_rows[r]);
        return v;
    endfunction

    function automatic void rand_vec();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) k_m[r][c] = int'($urandom_range(7)) - 4;
        for (int c = 0; c < C; c++) x_v[c] = int'($urandom_range(7)) - 4;
        load_vec();
    endfunction

    always @(posedge clk) begin
        if (cen === 1'b1) begin
            pipe[0] <= (s_valid === 1'b1) ? pack_rows() : W_V'($urandom);
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    // ---------------- monitor / scoreboard ----------------
    bit                    stall_prev = 1'b0;
    logic signed [W_Y-1:0] stall_data;
    logic [W_R-1:0]        stall_row;

    always @(negedge clk) begin
        beat_t e;
        if (mon_en) begin
            if (rst) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                n_vec++;
                if (s_ready !== cen) begin
                    n_err++;
                    $display("FAIL s_ready_eq_cen: s_ready=%b cen=%b", s_ready, cen);
                end
                if (stall_prev) begin
                    n_vec++;
                    if (m_valid !== 1'b1 || m_data !== stall_data || m_row !== stall_row) begin
                        n_err++;
                        $display("FAIL hold_stable: got valid=%b data=%0d row=%0d expected valid=1 data=%0d row=%0d",
                                 m_valid, m_data, m_row, stall_data, stall_row);
                    end
                end
                if (m_valid === 1'b1 && m_ready === 1'b1) begin
                    beats++;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_beat: got data=%0d row=%0d expected no beat", m_data, m_row);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(m_data) !== e.data || m_row !== W_R'(e.row) ||
                            m_last !== (e.row == R - 1)) begin
                            n_err++;
                            $display("FAIL beat: got data=%0d row=%0d last=%b expected data=%0d row=%0d last=%b",
                                     m_data, m_row, m_last, e.data, e.row, (e.row == R - 1));
                        end
                    end
                end else if (m_valid !== 1'b1) begin
                    n_vec++;
                    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
                        n_err++;
                        $display("FAIL idle_outputs: got valid=%b last=%b expected 0 0", m_valid, m_last);
                    end
                end
                if (s_valid === 1'b1 && s_ready === 1'b1) begin
                    for (int r = 0; r < R; r++) exp_q.push_back('{data: cur_rows[r], row: r});
                end
                stall_prev = (m_valid === 1'b1 && m_ready === 1'b0);
                stall_data = m_data;
                stall_row  = m_row;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present cur_rows and hold it until it is accepted (bounded).
    task automatic send();
        bit acc = 1'b0;
        int n   = 0;
        s_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = (s_ready === 1'b1);
            step();
            n++;
        end while (!acc && n < 200);
        s_valid = 1'b0;
        if (!acc) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got no accept expected accept within 200 cycles");
        end
    endtask

    task automatic wait_empty();
        bit done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            done = (exp_q.size() == 0 && m_valid === 1'b0);
        end
        step();
        n_vec++;
        if (!done) begin
            n_err++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0;
        repeat (3) step();
        @(negedge clk);
        n_vec += 2;
        if (cen !== 1'b0) begin n_err++; $display("FAIL reset_cen: got %b expected 0", cen); end
        if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        step();
        rst = 1'b0;
        @(negedge clk);
        n_vec += 4;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid: got %b expected 0", m_valid); end
        if (m_last !== 1'b0) begin n_err++; $display("FAIL post_reset_last: got %b expected 0", m_last); end
        if (m_row !== '0) begin n_err++; $display("FAIL post_reset_row: got %0d expected 0", m_row); end
        if (cen !== 1'b1) begin n_err++; $display("FAIL post_reset_cen: got %b expected 1", cen); end
        mon_en = 1'b1;
        step();
        m_ready = 1'b1;
    endtask

    task automatic test_single_vector();
        k_m[0][0] = 1; k_m[0][1] = 2; k_m[1][0] = 3; k_m[1][1] = -4;
        x_v[0] = 2; x_v[1] = -1;
        load_vec();
        m_ready = 1'b1;
        send();                                  // now in cycle t+1
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk);
            n_vec++;
            if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_early_valid: cycle t+%0d got %b expected 0", c, m_valid); end
            step();
        end
        @(negedge clk);                          // t+3
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== 7'sd0 || m_row !== 1'b0 || m_last !== 1'b0) begin
            n_err++;
            $display("FAIL single_beat0: got v=%b d=%0d r=%0d l=%b expected v=1 d=0 r=0 l=0", m_valid, m_data, m_row, m_last);
        end
        step();
        @(negedge clk);                          // t+4
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== 7'sd10 || m_row !== 1'b1 || m_last !== 1'b1) begin
            n_err++;
            $display("FAIL single_beat1: got v=%b d=%0d r=%0d l=%b expected v=1 d=10 r=1 l=1", m_valid, m_data, m_row, m_last);
        end
        step();
        @(negedge clk);                          // t+5
        n_vec++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL single_after: got %b expected 0", m_valid); end
        step();
    endtask

    task automatic test_extreme();
        k_m[0][0] = -4; k_m[0][1] = -4; k_m[1][0] = 3; k_m[1][1] = 3;
        x_v[0] = -4; x_v[1] = -4;
        load_vec();
        send();
        step(); step();                          // to cycle t+3
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== 7'sd32) begin
            n_err++; $display("FAIL extreme_beat0: got v=%b d=%0d expected v=1 d=32", m_valid, m_data);
        end
        step();
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b1 || m_data !== -7'sd24) begin
            n_err++; $display("FAIL extreme_beat1: got v=%b d=%0d expected v=1 d=-24", m_valid, m_data);
        end
        step();
        wait_empty();
    endtask

    task automatic test_back_to_back();
        int b0 = beats;
        m_ready = 1'b0;
        fork
            begin
                repeat (4) begin
                    rand_vec();
                    send();
                end
            end
            begin
                repeat (6) step();
                @(negedge clk);
                n_vec++;
                if (cen !== 1'b0 || m_valid !== 1'b1) begin
                    n_err++; $display("FAIL b2b_freeze: got cen=%b valid=%b expected cen=0 valid=1", cen, m_valid);
                end
                repeat (4) step();
                m_ready = 1'b1;
            end
        join
        wait_empty();
        n_vec++;
        if (beats - b0 != 8) begin n_err++; $display("FAIL b2b_beats: got %0d expected 8", beats - b0); end
    endtask

    task automatic test_drain_capture();
        m_ready = 1'b1;
        rand_vec();
        send();                                  // cycle t+1
        step();                                  // cycle t+2
        rand_vec();
        send();                                  // cycle t+3
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if (m_valid !== 1'b1 || m_row !== W_R'(i % 2) || cen !== 1'b1) begin
                n_err++;
                $display("FAIL overlap_cycle%0d: got v=%b row=%0d cen=%b expected v=1 row=%0d cen=1", i, m_valid, m_row, cen, i % 2);
            end
            step();
        end
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b0) begin n_err++; $display("FAIL overlap_end: got %b expected 0", m_valid); end
        step();
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b1;
        rand_vec();
        send();                                  // cycle t+1
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (cen !== 1'b0 || s_ready !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_cen: got cen=%b s_ready=%b expected 0 0", cen, s_ready);
        end
        step();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_vec++;
            if (m_valid !== 1'b0) begin n_err++; $display("FAIL mid_reset_quiet: cycle %0d got %b expected 0", c, m_valid); end
            step();
        end
        rand_vec();
        send();
        step(); step();                          // cycle t+3
        @(negedge clk);
        n_vec++;
        if (m_valid !== 1'b1 || m_row !== '0 || int'(m_data) !== cur_rows[0]) begin
            n_err++;
            $display("FAIL mid_reset_latency: got v=%b r=%0d d=%0d expected v=1 r=0 d=%0d", m_valid, m_row, m_data, cur_rows[0]);
        end
        step();
        wait_empty();
    endtask

    task automatic test_bubbles();
        int b0 = beats;
        fork
            begin
                rand_vec();
                send();                          // this cycle is the bubble
                step();
                rand_vec();
                send();
            end
            begin
                repeat (30) begin
                    m_ready = 1'($urandom_range(1));
                    step();
                end
                m_ready = 1'b1;
            end
        join
        wait_empty();
        n_vec++;
        if (beats - b0 != 4) begin n_err++; $display("FAIL bubbles_beats: got %0d expected 4", beats - b0); end
    endtask

    task automatic test_random_stream();
        int b0 = beats;
        fork
            begin
                repeat (30) begin
                    repeat ($urandom_range(2)) step();
                    rand_vec();
                    send();
                end
            end
            begin
                repeat (200) begin
                    m_ready = 1'($urandom_range(1));
                    step();
                end
                m_ready = 1'b1;
            end
        join
        m_ready = 1'b1;
        wait_empty();
        n_vec++;
        if (beats - b0 != 60) begin n_err++; $display("FAIL random_beats: got %0d expected 60", beats - b0); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_vector();
        test_extreme();
        test_back_to_back();
        test_drain_capture();
        test_reset_mid();
        test_bubbles();
        test_random_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/matvec_y_drain.md
Name: matvec_y_drain

Overview:
- Output-side companion to the matrix-vector multiply pipeline.
- Tracks which multiplier issue slots carry valid vectors and generates the pipeline clock-enable `cen`, with back-pressure.
- Captures each completed result vector `y` and streams it out one row per beat over a valid/ready interface with a last flag.
- Sits between the multiply pipeline and the downstream row consumer (accumulator/writeback).

Parameters:
R, 2, rows of result vector (number of beats per vector)
C, 2, columns of the multiplied matrix (sets pipeline depth)
W_X, 3, signed width of x elements
W_K, 3, signed width of k elements
W_Y, derived = W_X+W_K+$clog2(C), signed width of each y row
LAT, derived = $clog2(C)+1, pipeline latency in enabled cycles
W_R, derived = max(1,$clog2(R)), row index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  upstream presents a valid k/x pair to the multiplier this cycle
s_ready  out  1  upstream pair accepted this cycle when s_valid&&s_ready; equals cen
cen  out  1  clock enable driven to the multiply pipeline
y  in  R*W_Y  packed signed results from the multiply pipeline, row r at [r*W_Y +: W_Y]
m_data  out  W_Y  signed row result
m_row  out  W_R  index of the row on m_data
m_valid  out  1  m_data valid
m_ready  in  1  downstream accepts the beat
m_last  out  1  high on the beat carrying row R-1

Behaviour:
- State:
  - tag[LAT-1:0]: valid shift register.
  - buf[R]: W_Y-wide capture buffer.
  - buf_full: flag.
  - row: counter, 0..R-1.
- Reset (rst high at edge):
  - tag=0, buf_full=0, row=0.
  - While rst is high, cen=0 and s_ready=0 combinationally.
  - After reset: m_valid=0, m_last=0 (because row=0 and buf_full=0), m_row=0, m_data=buf[0] (don't-care while m_valid=0).
- Derived signals:
  - tag_top = tag[LAT-1].
  - fire = m_valid&&m_ready.
  - drain = fire&&m_last.
  - free = !buf_full || drain.
- cen = !rst && !(tag_top && !free). The pipeline freezes only when a finished vector is waiting and the buffer cannot take it.
- On an edge with cen=1:
  - tag[0] <= s_valid.
  - tag[i] <= tag[i-1] for i≥1.
- On an edge with cen=0: tag holds, and y is stable because the multiplier is also frozen.
- Capture: when tag_top && free at an edge, buf[r] <= y[r] for all r, and buf_full <= 1.
- Output path:
  - m_valid = buf_full.
  - m_data = buf[row], m_row = row.
  - m_last = buf_full && (row==R-1).
- On fire: row <= (row==R-1) ? 0 : row+1.
- On drain without capture in the same cycle: buf_full <= 0.
- Drain and capture in the same cycle:
  - buf_full stays 1 and the buffer reloads.
  - row returns to 0; the next vector streams with no bubble.
- Latency: a vector accepted in cycle t with cen continuously high gives m_valid=1, row 0, in cycle t+LAT+1.
- Throughput: sustained 1 vector per R cycles when m_ready=1. With R=1, 1 vector per cycle.
- s_valid with cen=0 is not accepted; upstream must hold its pair.
- Bubbles (s_valid=0 while accepted) propagate as tag=0 and are never emitted.
- m_valid, once high, stays high with m_data/m_row stable until fire.
- Reset mid-operation clears tags and buffer. In-flight multiplier contents become stale and are never emitted. No partial vector is resumed.
- All arithmetic on y is pass-through; no width change or sign manipulation.

Test Plan:
1. Single vector. Setup: R=2, C=2, W_X=W_K=3, k=[[1,2],[3,-4]], x=[2,-1], s_valid for one cycle t, m_ready=1. Required: m_valid rises at t+3 with (m_data=0, m_row=0, m_last=0), then (m_data=10, m_row=1, m_last=1), then m_valid=0.
2. Extreme values. Setup: k=[[-4,-4],[3,3]], x=[-4,-4], m_ready=1. Required: beats 32 then -24; no overflow at W_Y=7.
3. Back-to-back with back-pressure. Setup: 4 vectors issued every cycle, m_ready=0 for 10 cycles, then 1. Required:
   - cen drops once the buffer is full and tag_top is set.
   - No vector is lost or duplicated.
   - 8 beats follow in order; m_data is stable while stalled.
4. Simultaneous drain/capture. Setup: two vectors issued 2 cycles apart, m_ready=1. Required:
   - The last beat of vector 1 and the capture of vector 2 occur on the same edge.
   - m_valid stays high continuously, row wraps 1→0, and cen never drops.
5. Reset mid-flight. Setup: issue a vector, then assert rst at t+1 for one cycle. Required:
   - cen=0 during rst.
   - m_valid stays 0 for 10 cycles afterwards.
   - A new vector issued later emits correctly with latency 3.
6. Bubbles. Setup: s_valid pattern 1,0,1 with m_ready random 50%. Required: exactly 2 vectors (4 beats) are emitted, matching a reference model.
